// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the write arbiter and the register file.
// master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [AW-1:0]      req_addr0;
  logic [AW-1:0]      req_addr1;
  logic [DW-1:0]      req_data0;
  logic [DW-1:0]      req_data1;
  logic               rf_write;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_data;
  logic [2**AW-1:0]   pending_mask;
  logic               grant_id;

  modport master (
    output req_valid, req_addr0, req_addr1, req_data0, req_data1,
    input  req_ready, rf_write, rf_addr, rf_data, pending_mask, grant_id
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
    output req_ready, rf_write, rf_addr, rf_data, pending_mask, grant_id
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the register file, one hold entry per requester.
// Define RF_WRITE_ARB_RR_EN for round-robin on different-address conflicts; default is fixed load-first priority.
module regfile_write_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  logic [1:0]           hv_q, hv_d;
  logic [1:0][AW-1:0]   ha_q, ha_d;
  logic [1:0][DW-1:0]   hd_q, hd_d;
  logic                 age_q, age_d;  // 1: entry 1 is the older one
`ifdef RF_WRITE_ARB_RR_EN
  logic                 rr_q, rr_d;    // requester favoured on the next contended grant
`endif

  logic                 rf_write_q, rf_write_d;
  logic [AW-1:0]        rf_addr_q, rf_addr_d;
  logic [DW-1:0]        rf_data_q, rf_data_d;
  logic                 grant_id_q, grant_id_d;

  logic [1:0]           gnt;
  logic                 g_idx;
  logic [1:0]           ready;
  logic [1:0]           accept;
  logic [2**AW-1:0]     pending;

  // Grant: same-address pairs go oldest first so program order survives.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt = 2'b00;
    case (hv_q)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (ha_q[0] == ha_q[1]) begin
          gnt = age_q ? 2'b10 : 2'b01;
        end else begin
`ifdef RF_WRITE_ARB_RR_EN
          gnt = rr_q ? 2'b10 : 2'b01;
`else
          gnt = 2'b10;
`endif
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  assign g_idx  = gnt[1];
  assign ready  = ~hv_q | gnt;
  assign accept = bus.req_valid & ready;

  always_comb begin
    hv_d       = accept | (hv_q & ~gnt);
    ha_d       = ha_q;
    hd_d       = hd_q;
    age_d      = age_q;
    rf_write_d = |gnt;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    grant_id_d = grant_id_q;

    if (accept[0]) begin
      ha_d[0] = bus.req_addr0;
      hd_d[0] = bus.req_data0;
    end
    if (accept[1]) begin
      ha_d[1] = bus.req_addr1;
      hd_d[1] = bus.req_data1;
    end

    // A lone load makes that entry the younger one; a joint load treats the load (entry 1) as older.
    if (accept == 2'b11)  age_d = 1'b1;
    else if (accept[1])   age_d = 1'b0;
    else if (accept[0])   age_d = 1'b1;

    if (|gnt) begin
      rf_addr_d  = ha_q[g_idx];
      rf_data_d  = hd_q[g_idx];
      grant_id_d = g_idx;
    end
  end

`ifdef RF_WRITE_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (hv_q == 2'b11) rr_d = ~g_idx;
  end
`endif

  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++) begin
      if (hv_q[i]) pending[ha_q[i]] = 1'b1;
    end
    if (rf_write_q) pending[rf_addr_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hv_q       <= 2'b00;
      age_q      <= 1'b0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      grant_id_q <= 1'b0;
`ifdef RF_WRITE_ARB_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      hv_q       <= hv_d;
      age_q      <= age_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      grant_id_q <= grant_id_d;
`ifdef RF_WRITE_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // NOTE: hold-entry payload is not reset; hv_q alone says whether it is meaningful.
  always_ff @(posedge clock) begin
    ha_q <= ha_d;
    hd_q <= hd_d;
  end

  assign bus.req_ready    = ready;
  assign bus.rf_write     = rf_write_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_data      = rf_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.pending_mask = pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus queues push expected writes into a scoreboard
// that a negedge monitor drains; expectations switch with RF_WRITE_ARB_RR_EN.
module tb_regfile_write_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct packed { logic id; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  req_t        src0[$], src1[$];
  wr_t         exp_q[$];
  logic [1:0]  ready_log[$];
  logic        wr_log[$];
  logic [7:0]  pm_log[$];
  logic [DW-1:0] shadow [8];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic req_t rq(input int a, input int d);
    rq.addr = a[AW-1:0];
    rq.data = d[DW-1:0];
  endfunction

  function automatic wr_t w(input int id, input int a, input int d);
    w.id   = id[0];
    w.addr = a[AW-1:0];
    w.data = d[DW-1:0];
  endfunction

  // Scoreboard monitor: every register-file write must match the next expected write.
  always @(negedge clock) begin
    if (!reset && bus.rf_write === 1'b1) begin
      shadow[bus.rf_addr] = bus.rf_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write", bus.rf_addr, bus.rf_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("rf_write_seq", {bus.grant_id, bus.rf_addr, bus.rf_data}, e);
      end
    end
  end

  // Present queued requests for n cycles; iteration k logs outputs seen after edge k.
  task automatic run(input int n);
    logic [1:0] acc;
    ready_log.delete();
    wr_log.delete();
    pm_log.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      ready_log.push_back(bus.req_ready);
      wr_log.push_back(bus.rf_write);
      pm_log.push_back(bus.pending_mask);
      bus.req_valid = {src1.size() != 0, src0.size() != 0};
      if (src0.size() != 0) begin
        bus.req_addr0 = src0[0].addr;
        bus.req_data0 = src0[0].data;
      end
      if (src1.size() != 0) begin
        bus.req_addr1 = src1[0].addr;
        bus.req_data1 = src1[0].data;
      end
      acc = bus.req_valid & bus.req_ready;
      @(posedge clock);
      if (acc[0]) void'(src0.pop_front());
      if (acc[1]) void'(src1.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drained(input string name);
    check({name, "_all_accepted"}, src0.size() + src1.size(), 0);
    check({name, "_all_written"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    #1;
    check("reset_rf_write", bus.rf_write, 0);
    check("reset_pending", bus.pending_mask, 0);
    check("reset_ready", bus.req_ready, 2'b11);
    do_reset();

    // Single write
    src0.push_back(rq(3, 8'h5A));
    exp_q.push_back(w(0, 3, 8'h5A));
    run(4);
    check("single_wr_c1", wr_log[1], 0);
    check("single_wr_c2", wr_log[2], 1);
    check("single_wr_c3", wr_log[3], 0);
    check("single_pm_c1", pm_log[1], 8'h08);
    check("single_pm_c2", pm_log[2], 8'h08);
    check("single_pm_c3", pm_log[3], 8'h00);
    drained("single");

    // Different-address collision, twice in a row
    do_reset();
    for (int r = 0; r < 2; r++) begin
      src0.push_back(rq(1, 8'h11));
      src1.push_back(rq(2, 8'h22));
`ifdef RF_WRITE_ARB_RR_EN
      if (r == 0) begin
        exp_q.push_back(w(0, 1, 8'h11));
        exp_q.push_back(w(1, 2, 8'h22));
      end else begin
        exp_q.push_back(w(1, 2, 8'h22));
        exp_q.push_back(w(0, 1, 8'h11));
      end
`else
      exp_q.push_back(w(1, 2, 8'h22));
      exp_q.push_back(w(0, 1, 8'h11));
`endif
      run(4);
      check("collide_wr_c2", wr_log[2], 1);
      check("collide_wr_c3", wr_log[3], 1);
      drained("collide");
    end

    // Same address, req0 one cycle ahead of req1
    do_reset();
    src0.push_back(rq(4, 8'hAA));
    run(1);
    src1.push_back(rq(4, 8'hBB));
    exp_q.push_back(w(0, 4, 8'hAA));
    exp_q.push_back(w(1, 4, 8'hBB));
    run(4);
    check("same_addr_seq_final", shadow[4], 8'hBB);
    drained("same_addr_seq");

    // Same address, both accepted at one edge: load first
    do_reset();
    src0.push_back(rq(4, 8'hAA));
    src1.push_back(rq(4, 8'hBB));
    exp_q.push_back(w(1, 4, 8'hBB));
    exp_q.push_back(w(0, 4, 8'hAA));
    run(4);
    check("same_addr_joint_pm", pm_log[1], 8'h10);
    check("same_addr_joint_final", shadow[4], 8'hAA);
    drained("same_addr_joint");

    // Entry 0 becomes older than a reloaded entry 1 on the same address
    do_reset();
    src0.push_back(rq(4, 8'hAA));
    src1.push_back(rq(5, 8'hCC));
    src1.push_back(rq(4, 8'hBB));
`ifdef RF_WRITE_ARB_RR_EN
    exp_q.push_back(w(0, 4, 8'hAA));
    exp_q.push_back(w(1, 5, 8'hCC));
`else
    exp_q.push_back(w(1, 5, 8'hCC));
    exp_q.push_back(w(0, 4, 8'hAA));
`endif
    exp_q.push_back(w(1, 4, 8'hBB));
    run(6);
    check("age_final", shadow[4], 8'hBB);
    drained("age");

    // Back-pressure: both requesters keep offering
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src0.push_back(rq(i, 8'hA0 + i));
      src1.push_back(rq(5 + i, 8'hB0 + i));
    end
`ifdef RF_WRITE_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(w(0, i, 8'hA0 + i));
      exp_q.push_back(w(1, 5 + i, 8'hB0 + i));
    end
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(w(1, 5 + i, 8'hB0 + i));
    for (int i = 0; i < 3; i++) exp_q.push_back(w(0, i, 8'hA0 + i));
`endif
    run(9);
`ifdef RF_WRITE_ARB_RR_EN
    for (int k = 1; k <= 5; k++) check("bp_ready", ready_log[k], (k % 2 == 1) ? 2'b01 : 2'b10);
`else
    for (int k = 1; k <= 3; k++) check("bp_ready", ready_log[k], 2'b10);
`endif
    for (int k = 2; k <= 7; k++) check("bp_rf_write", wr_log[k], 1);
    drained("bp");

    // Reset mid-operation with both entries full and a write on the rf port
    do_reset();
    src0.push_back(rq(1, 8'h31));
    src1.push_back(rq(2, 8'h32));
    run(2);
    #1;
    check("pre_reset_rf_write", bus.rf_write, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_rf_write", bus.rf_write, 0);
    check("mid_reset_rf_addr", bus.rf_addr, 0);
    check("mid_reset_rf_data", bus.rf_data, 0);
    check("mid_reset_grant_id", bus.grant_id, 0);
    check("mid_reset_pending", bus.pending_mask, 0);
    check("mid_reset_ready", bus.req_ready, 2'b11);
    #1;
    reset = 1'b0;
    run(3);
    for (int k = 0; k < 3; k++) begin
      check("post_reset_ready", ready_log[k], 2'b11);
      check("post_reset_no_write", wr_log[k], 0);
    end
    drained("reset");

    // Streaming from requester 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src0.push_back(rq(i, i));
      exp_q.push_back(w(0, i, i));
    end
    run(11);
    for (int k = 0; k < 8; k++) check("stream_ready0", ready_log[k][0], 1);
    for (int k = 2; k <= 9; k++) check("stream_rf_write", wr_log[k], 1);
    check("stream_end_idle", wr_log[10], 0);
    drained("stream");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
